// File: rtl/cv32e40p_sleep_unit_mc.sv
// ---------------------------------------------------------------------------
// cv32e40p_sleep_unit_mc
//
// Multi-domain sleep unit. Each of NUM_DOMAINS clock domains has its own
// gate and its own small FSM. The FSM waits out an idle hysteresis before it
// gates the clock, and it waits out a wake latency before it reports the
// domain ready again. The sticky fetch-enable function of the original
// single-gate unit is kept.
//
// Ports:
//   clk_ungated_i   free-running clock; the only clock of this block
//   rst_i           asynchronous, active-high reset
//   scan_cg_en_i    forces every gate transparent (test mode)
//   fetch_enable_i  fetch enable request from the core
//   fetch_enable_o  sticky fetch enable
//   busy_i          per-domain busy (registered before the FSMs use it)
//   wake_i          per-domain wake request (combinational path to the gate)
//   force_on_i      per-domain keep-alive; blocks gating
//   clk_gated_o     per-domain gated clocks
//   domain_ready_o  per-domain: clock running and domain usable
//   domain_sleep_o  per-domain: gated with its clock disabled
//   core_sleep_o    every domain asleep
// ---------------------------------------------------------------------------

module cv32e40p_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic en_latch;

    // The enable is latched while the clock is low, so a change that
    // arrives during the high phase cannot clip the running pulse.
    always_latch begin
        if (!clk_i) begin
            en_latch <= en_i | scan_cg_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

module cv32e40p_sleep_unit_mc #(
    parameter int NUM_DOMAINS = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 1,
    parameter int CNT_W       = $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst_i,
    input  logic                   scan_cg_en_i,
    input  logic                   fetch_enable_i,
    output logic                   fetch_enable_o,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] wake_i,
    input  logic [NUM_DOMAINS-1:0] force_on_i,
    output logic [NUM_DOMAINS-1:0] clk_gated_o,
    output logic [NUM_DOMAINS-1:0] domain_ready_o,
    output logic [NUM_DOMAINS-1:0] domain_sleep_o,
    output logic                   core_sleep_o
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_WAKE   = 3'd1,
        S_ACTIVE = 3'd2,
        S_DRAIN  = 3'd3,
        S_GATED  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);

    logic                   fetch_enable_q;
    logic [NUM_DOMAINS-1:0] busy_q;

    // Fetch enable is sticky until reset; busy is registered once here so
    // every FSM decision sees the same, glitch-free copy.
    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_enable_q <= 1'b0;
            busy_q         <= '0;
        end else begin
            if (fetch_enable_i) begin
                fetch_enable_q <= 1'b1;
            end
            busy_q <= busy_i;
        end
    end

    assign fetch_enable_o = fetch_enable_q;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_domain

        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             keep_awake;
        logic             clk_en;
        logic             ready;

        assign keep_awake = busy_q[d] | wake_i[d] | force_on_i[d];

        // State and shared wake/idle counter.
        always_ff @(posedge clk_ungated_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Transitions. A keep-awake reason in DRAIN always beats an expiring
        // idle count, so a late wake never loses its clock.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_OFF: begin
                    if (fetch_enable_q) begin
                        state_d = S_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end
                end
                S_WAKE: begin
                    if (cnt_q == '0) begin
                        state_d = S_ACTIVE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (!keep_awake) begin
                        if (IDLE_CYCLES == 0) begin
                            state_d = S_GATED;
                        end else begin
                            state_d = S_DRAIN;
                            cnt_d   = IDLE_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    if (keep_awake) begin
                        state_d = S_ACTIVE;
                    end else if (cnt_q == '0) begin
                        state_d = S_GATED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_GATED: begin
                    if (wake_i[d] | force_on_i[d]) begin
                        state_d = S_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        // Gate enable and ready decode. In GATED the wake request opens the
        // gate directly so the domain sees its waking edge this cycle.
        always_comb begin
            clk_en = 1'b0;
            ready  = 1'b0;
            case (state_q)
                S_WAKE: begin
                    clk_en = 1'b1;
                end
                S_ACTIVE, S_DRAIN: begin
                    clk_en = 1'b1;
                    ready  = 1'b1;
                end
                S_GATED: begin
                    clk_en = wake_i[d] | force_on_i[d];
                end
                default: begin
                    clk_en = 1'b0;
                    ready  = 1'b0;
                end
            endcase
        end

        assign domain_ready_o[d] = ready;
        assign domain_sleep_o[d] = (state_q == S_GATED) & ~clk_en;

        cv32e40p_clock_gate u_clock_gate (
            .clk_i        (clk_ungated_i),
            .en_i         (clk_en),
            .scan_cg_en_i (scan_cg_en_i),
            .clk_o        (clk_gated_o[d])
        );
    end

    assign core_sleep_o = fetch_enable_q & (&domain_sleep_o);

endmodule

// File: tb/tb_cv32e40p_sleep_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_sleep_unit_mc
//
// Directed and randomized bench for the multi-domain sleep unit, configured
// with two domains, a three-cycle idle hysteresis and a two-cycle wake.
// The reference model describes each domain by how long it has been waking
// and how long it has been idle, rather than by named states.
// ---------------------------------------------------------------------------

module tb_cv32e40p_sleep_unit_mc;

    localparam int ND = 2;
    localparam int IC = 3;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan;
    logic          fe_in;
    logic [ND-1:0] busy;
    logic [ND-1:0] wake;
    logic [ND-1:0] force_on;
    logic          fe_out;
    logic [ND-1:0] clk_gated;
    logic [ND-1:0] ready;
    logic [ND-1:0] sleep;
    logic          core_sleep;

    int checks = 0;
    int passed = 0;

    // Reference model state.
    bit            m_feq;
    bit [ND-1:0]   m_busy_q;
    bit            m_powered [ND];
    bit            m_gated   [ND];
    int            m_wake_age[ND];
    int            m_idle_run[ND];

    cv32e40p_sleep_unit_mc #(
        .NUM_DOMAINS (ND),
        .IDLE_CYCLES (IC),
        .WAKE_CYCLES (WC)
    ) dut (
        .clk_ungated_i  (clk),
        .rst_i          (rst),
        .scan_cg_en_i   (scan),
        .fetch_enable_i (fe_in),
        .fetch_enable_o (fe_out),
        .busy_i         (busy),
        .wake_i         (wake),
        .force_on_i     (force_on),
        .clk_gated_o    (clk_gated),
        .domain_ready_o (ready),
        .domain_sleep_o (sleep),
        .core_sleep_o   (core_sleep)
    );

    always #5 clk = ~clk;

    // Hard stop in case anything ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit m_clk_en(int d);
        return m_powered[d] && (!m_gated[d] || wake[d] || force_on[d]);
    endfunction

    function automatic bit m_ready(int d);
        return m_powered[d] && !m_gated[d] && (m_wake_age[d] >= WC);
    endfunction

    function automatic bit m_sleep(int d);
        return m_gated[d] && !(wake[d] || force_on[d]);
    endfunction

    task automatic model_reset();
        m_feq    = 1'b0;
        m_busy_q = '0;
        for (int d = 0; d < ND; d++) begin
            m_powered[d]  = 1'b0;
            m_gated[d]    = 1'b0;
            m_wake_age[d] = 0;
            m_idle_run[d] = 0;
        end
    endtask

    // One clock edge: a domain becomes usable after WC edges of waking and
    // gates after IC+1 consecutive idle edges while usable.
    task automatic model_edge();
        bit [ND-1:0] bq;
        bit          feq_old;
        bq      = m_busy_q;
        feq_old = m_feq;
        for (int d = 0; d < ND; d++) begin
            if (!m_powered[d]) begin
                if (feq_old) begin
                    m_powered[d]  = 1'b1;
                    m_gated[d]    = 1'b0;
                    m_wake_age[d] = 0;
                    m_idle_run[d] = 0;
                end
            end else if (m_gated[d]) begin
                if (wake[d] || force_on[d]) begin
                    m_gated[d]    = 1'b0;
                    m_wake_age[d] = 0;
                    m_idle_run[d] = 0;
                end
            end else if (m_wake_age[d] < WC) begin
                m_wake_age[d]++;
            end else if (bq[d] || wake[d] || force_on[d]) begin
                m_idle_run[d] = 0;
            end else begin
                m_idle_run[d]++;
                if (m_idle_run[d] == IC + 1) begin
                    m_gated[d]    = 1'b1;
                    m_idle_run[d] = 0;
                end
            end
        end
        m_busy_q = busy;
        if (fe_in) m_feq = 1'b1;
    endtask

    task automatic check(string tag, logic [7:0] observed, logic [7:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_output();
        logic [ND-1:0] exp_ready;
        logic [ND-1:0] exp_sleep;
        for (int d = 0; d < ND; d++) begin
            exp_ready[d] = m_ready(d);
            exp_sleep[d] = m_sleep(d);
        end
        check("fetch_enable_o", {7'b0, fe_out}, {7'b0, m_feq});
        check("domain_ready_o", {6'b0, ready}, {6'b0, exp_ready});
        check("domain_sleep_o", {6'b0, sleep}, {6'b0, exp_sleep});
        check("core_sleep_o", {7'b0, core_sleep}, {7'b0, (m_feq && (&exp_sleep))});
    endtask

    // One full clock cycle: predict the gated high phase from the enable
    // seen during the preceding low phase, then check outputs and the
    // following low phase.
    task automatic apply_stimulus();
        logic [ND-1:0] exp_gclk;
        for (int d = 0; d < ND; d++) begin
            exp_gclk[d] = m_clk_en(d) | scan;
        end
        @(posedge clk);
        if (!rst) model_edge();
        #2;
        check_output();
        check("clk_gated_high", {6'b0, clk_gated}, {6'b0, exp_gclk});
        #4;
        check("clk_gated_low", {6'b0, clk_gated}, 8'h00);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    initial begin
        rst      = 1'b1;
        scan     = 1'b0;
        fe_in    = 1'b0;
        busy     = '0;
        wake     = '0;
        force_on = '0;
        model_reset();
        #1;
        check_output();
        run(2);
        rst = 1'b0;

        // Bring-up: sticky fetch enable, both domains wake.
        fe_in = 1'b1;
        busy  = 2'b11;
        run(1);
        check("fe_after_edge1", {7'b0, fe_out}, 8'h01);
        fe_in = 1'b0;
        run(3);
        check("ready_after_edge4", {6'b0, ready}, 8'h03);

        // Domain 0 idles down while domain 1 stays busy.
        busy = 2'b10;
        run(5);
        check("sleep_dom0_only", {6'b0, sleep}, 8'h01);
        check("core_awake", {7'b0, core_sleep}, 8'h00);

        // Both asleep, then wake domain 1 combinationally.
        busy = 2'b00;
        run(5);
        check("core_asleep", {7'b0, core_sleep}, 8'h01);
        wake = 2'b10;
        #1;
        check_output();
        check("core_wakes_same_cycle", {7'b0, core_sleep}, 8'h00);
        run(1);
        wake = 2'b00;
        busy = 2'b10;
        run(2);
        check("dom1_ready_dom0_asleep", {6'b0, ready, sleep[0]}, 8'h05);

        // Wake domain 0, then cancel its drain one cycle before gating.
        busy = 2'b11;
        wake = 2'b01;
        run(1);
        wake = 2'b00;
        run(3);
        busy = 2'b10;
        run(3);
        busy = 2'b11;
        run(4);
        check("drain_cancelled", {7'b0, ready[0]}, 8'h01);
        busy = 2'b10;
        run(6);

        // force_on wakes a gated domain and then holds it active.
        force_on = 2'b01;
        run(3);
        busy = 2'b00;
        run(8);
        check("force_holds_active", {6'b0, ready}, 8'h01);
        force_on = 2'b00;
        run(6);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < ND; d++) begin
                busy[d]     = ($urandom_range(0, 3) == 0);
                wake[d]     = ($urandom_range(0, 7) == 0);
                force_on[d] = ($urandom_range(0, 15) == 0);
            end
            apply_stimulus();
        end

        // Reset in the middle of a drain.
        busy     = 2'b11;
        wake     = 2'b11;
        force_on = 2'b00;
        run(3);
        wake = 2'b00;
        run(2);
        busy = 2'b00;
        run(3);
        rst = 1'b1;
        #1;
        model_reset();
        check_output();
        check("reset_fe_low", {7'b0, fe_out}, 8'h00);
        check("reset_ready_low", {6'b0, ready}, 8'h00);
        run(2);
        rst = 1'b0;

        // Re-enable, let everything gate, then check scan transparency.
        fe_in = 1'b1;
        run(1);
        fe_in = 1'b0;
        run(9);
        check("all_gated_before_scan", {6'b0, sleep}, 8'h03);
        scan = 1'b1;
        run(3);
        check("scan_sleep_unchanged", {6'b0, sleep}, 8'h03);
        scan = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_sleep_unit_mc.md
Name: cv32e40p_sleep_unit_mc

Overview:
- Multi-domain successor to the single-gate sleep unit.
- Owns NUM_DOMAINS independent clock gates. Each gate is driven by a per-domain FSM with:
  - programmable idle hysteresis before gating;
  - programmable wake latency before reporting the domain ready.
- Keeps the sticky fetch-enable function.
- Reports per-domain sleep and a global core sleep.
- Sits between the free-running clock and the core sub-units: controller/IF domain, LSU domain, APU domain.

Parameters:
- NUM_DOMAINS, 2: number of independently gated clock domains (1..8).
- IDLE_CYCLES, 4: consecutive idle cycles required before gating a domain. 0 = gate on the first idle cycle, with no DRAIN state.
- WAKE_CYCLES, 1: cycles spent in WAKE with clock running before domain_ready_o asserts. Must be at least 1.
- CNT_W, $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1): width of the shared-format down counter.

Ports:
- clk_ungated_i  in  1  free-running clock; sole clock of the block
- rst_i  in  1  asynchronous, active-high reset
- scan_cg_en_i  in  1  forces all gates transparent for test
- fetch_enable_i  in  1  core fetch enable request
- fetch_enable_o  out  1  sticky fetch enable
- busy_i  in  NUM_DOMAINS  per-domain busy
- wake_i  in  NUM_DOMAINS  per-domain wake request (combinational path to gate enable)
- force_on_i  in  NUM_DOMAINS  per-domain keep-alive (debug); blocks gating
- clk_gated_o  out  NUM_DOMAINS  gated clocks, one cv32e40p_clock_gate per domain
- domain_ready_o  out  NUM_DOMAINS  domain in ACTIVE or DRAIN
- domain_sleep_o  out  NUM_DOMAINS  domain gated and clock disabled
- core_sleep_o  out  1  all domains sleeping

Behaviour:
- Reset (rst_i=1, async):
  - fetch_enable_q=0, busy_q=0, every FSM in OFF, counters 0.
  - All outputs 0; all gates closed unless scan_cg_en_i=1.
- Sticky enable: fetch_enable_q sets on fetch_enable_i and clears only on reset. fetch_enable_o = fetch_enable_q.
- busy_q[i] is a registered copy of busy_i[i]. All FSM decisions use busy_q, never raw busy_i.
- Per-domain FSM, state encoding OFF/WAKE/ACTIVE/DRAIN/GATED:
  - OFF: clk_en=0. If fetch_enable_q=1 → WAKE, cnt=WAKE_CYCLES-1.
  - WAKE: clk_en=1, ready=0. cnt==0 → ACTIVE, else cnt--.
  - ACTIVE: clk_en=1, ready=1.
    - busy_q, wake_i or force_on_i high → stay.
    - Otherwise, IDLE_CYCLES==0 → GATED.
    - Otherwise → DRAIN, cnt=IDLE_CYCLES-1.
  - DRAIN: clk_en=1, ready=1.
    - busy_q, wake_i or force_on_i high → ACTIVE (cancel; counter discarded).
    - Otherwise cnt==0 → GATED, else cnt--.
  - GATED: clk_en = wake_i | force_on_i, combinational, so the waking edge reaches the domain in the same cycle.
    - wake_i | force_on_i → WAKE, cnt=WAKE_CYCLES-1.
- Output decode:
  - domain_sleep_o[i] = (state==GATED) & ~clk_en[i].
  - domain_ready_o[i] = state ∈ {ACTIVE, DRAIN}.
  - core_sleep_o = fetch_enable_q & AND(domain_sleep_o).
- Gate enable per domain is clk_en[i]; the gate is transparent when scan_cg_en_i=1. The FSMs still run on clk_ungated_i.
- Domains are fully independent; there is no ordering between domains.
- Boundaries:
  - wake and idle expiry in the same cycle: wake wins.
  - force_on_i held high: the domain never leaves ACTIVE.
  - reset mid-WAKE/DRAIN: immediate return to OFF, outputs 0.
  - fetch_enable_i deassert after set: no effect.

Test Plan (NUM_DOMAINS=2, IDLE_CYCLES=3, WAKE_CYCLES=2):
- Reset, then fetch_enable_i=1 for one cycle, sampled at edge 1:
  - fetch_enable_o=1 after edge 1.
  - Both domains in WAKE after edge 2, clk_gated_o toggling.
  - domain_ready_o=2'b11 after edge 4.
- Domain 0 busy_i falls before edge k, others held busy:
  - DRAIN after edge k+1, GATED after edge k+4.
  - domain_sleep_o=2'b01, clk_gated_o[0] flat, core_sleep_o=0.
- Both domains idle to GATED, then pulse wake_i[1]:
  - clk_gated_o[1] pulses in the same cycle; core_sleep_o drops in the same cycle.
  - domain 1 ready 2 cycles after entering WAKE; domain 0 stays asleep.
- Domain 0 in DRAIN with cnt=1, then busy_i=1: returns to ACTIVE, never gates; a later idle period restarts the full 3-cycle count.
- force_on_i[0]=1 while idle: stays ACTIVE indefinitely. force_on_i[0] asserted in GATED → WAKE.
- rst_i asserted mid-DRAIN and scan_cg_en_i=1 while GATED:
  - reset: all outputs 0 immediately and fetch_enable_o=0.
  - scan: clk_gated_o follows clk_ungated_i with domain_sleep_o unchanged.
